// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the segmented carry-lookahead adder.
// Provides the segment width, FSM state type and counter-width helper.
package cla_seq_pkg;

    localparam int unsigned SEG_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cla_seq_state_t;

    // Counter width for nseg segments; never narrower than one bit.
    function automatic int unsigned seg_idx_w(input int unsigned nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with group
// generate/propagate terms feeding a lookahead carry unit.
module cla_16bit
    import cla_seq_pkg::*;
(
    input  logic [SEG_W-1:0] A,
    input  logic [SEG_W-1:0] B,
    input  logic             Cin,
    output logic [SEG_W-1:0] Sum,
    output logic             Cout
);

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [3:0]       grp_g;
    logic [3:0]       grp_p;
    logic [4:0]       grp_c;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin
        logic gg_acc;
        logic gp_acc;
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 4; k++) begin
            gg_acc = 1'b0;
            gp_acc = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gg_acc = g[4*k+j] | (p[4*k+j] & gg_acc);
                gp_acc = gp_acc & p[4*k+j];
            end
            grp_g[k] = gg_acc;
            grp_p[k] = gp_acc;
        end
    end

    // Second-level lookahead: every group carry is a flat function of Cin.
    assign grp_c[0] = Cin;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & Cin);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Cin);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & Cin);
    assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & Cin);
    assign Cout = grp_c[4];

    always_comb begin
        logic c;
        Sum = '0;
        for (int k = 0; k < 4; k++) begin
            c = grp_c[k];
            for (int j = 0; j < 4; j++) begin
                Sum[4*k+j] = p[4*k+j] ^ c;
                c = g[4*k+j] | (p[4*k+j] & c);
            end
        end
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle W-bit adder/subtractor reusing one cla_16bit across NSEG
// segments, with the inter-segment carry held in a register.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned NSEG = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEG_W*NSEG-1:0]   a,
    input  logic [SEG_W*NSEG-1:0]   b,
    input  logic                    cin,
    input  logic                    op_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEG_W*NSEG-1:0]   sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int unsigned W  = SEG_W * NSEG;
    localparam int unsigned CW = seg_idx_w(NSEG);
    localparam logic [CW-1:0] LAST_SEG = CW'(NSEG - 1);

    cla_seq_state_t state_q, state_d;
    logic [CW-1:0]  seg_cnt_q, seg_cnt_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] add_sum;
    logic             add_cout;

    assign seg_a = a_q[seg_cnt_q*SEG_W +: SEG_W];
    assign seg_b = b_q[seg_cnt_q*SEG_W +: SEG_W];

    cla_16bit u_cla (
        .A    (seg_a),
        .B    (seg_b),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        seg_cnt_d   = seg_cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
                    a_d       = a;
                    b_d       = op_sub ? ~b : b;
                    carry_d   = op_sub ? 1'b1 : cin;
                    seg_cnt_d = '0;
                    sum_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                sum_d[seg_cnt_q*SEG_W +: SEG_W] = add_sum;
                carry_d = add_cout;
                if (seg_cnt_q == LAST_SEG) begin
                    cout_d      = add_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    seg_cnt_d = seg_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seg_cnt_q   <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at NSEG = 1, 2 and 4 against an
// arithmetic reference model plus directed literal vectors.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic        cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        rand_ready = 1'b0;
    int          sel = 0;
    longint      cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [2:0]  iv, ordy, irdy, ov, co, bsy;
    logic [15:0] sum1;
    logic [31:0] sum2;
    logic [63:0] sum4;
    logic [63:0] sum_m;
    logic        in_ready_m, out_valid_m, cout_m, busy_m;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        longint      acc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_route
        assign iv[k]   = in_valid && (sel == k);
        assign ordy[k] = out_ready && (sel == k);
    end

    cla_seq_adder #(.NSEG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .op_sub(op_sub),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum1), .cout(co[0]), .busy(bsy[0])
    );
    cla_seq_adder #(.NSEG(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin), .op_sub(op_sub),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum2), .cout(co[1]), .busy(bsy[1])
    );
    cla_seq_adder #(.NSEG(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a_in), .b(b_in), .cin(cin), .op_sub(op_sub),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum4), .cout(co[2]), .busy(bsy[2])
    );

    always_comb begin
        sum_m = '0;
        case (sel)
            0:       sum_m = {48'd0, sum1};
            1:       sum_m = {32'd0, sum2};
            default: sum_m = sum4;
        endcase
        in_ready_m  = irdy[sel];
        out_valid_m = ov[sel];
        cout_m      = co[sel];
        busy_m      = bsy[sel];
    end

    function automatic exp_t golden(input logic [63:0] a, input logic [63:0] b,
                                    input logic c, input logic s, input int w);
        exp_t        e;
        logic [64:0] m, aa, bb, r;
        m  = (65'd1 << w) - 65'd1;
        aa = {1'b0, a} & m;
        bb = {1'b0, b} & m;
        r  = s ? (aa + ((~bb) & m) + 65'd1) : (aa + bb + {64'd0, c});
        e.cout = r[w];
        e.sum  = r[63:0] & m[63:0];
        e.acc  = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one operation and return at posedge+1 after its accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic s);
        int   n = 0;
        exp_t e;
        a_in = a; b_in = b; cin = c; op_sub = s; in_valid = 1'b1;
        while (!in_ready_m && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready_m) begin
            chk("accept_wait", {63'd0, in_ready_m}, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            e     = golden(a, b, c, s, 16 << sel);
            e.acc = cyc;
            exp_q.push_back(e);
            in_valid = 1'b0;
            a_in     = {$urandom, $urandom};
            b_in     = {$urandom, $urandom};
            cin      = 1'($urandom);
            op_sub   = 1'($urandom);
        end
    endtask

    task automatic wait_result();
        int n = 0;
        while (!out_valid_m && n < 50) begin
            @(negedge clk); n++;
        end
        chk("result_wait", {63'd0, out_valid_m}, 64'd1);
    endtask

    task automatic op_lit(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s, input logic [63:0] es,
                          input logic ec);
        send(a, b, c, s);
        wait_result();
        chk({name, "_sum"}, sum_m, es);
        chk({name, "_cout"}, {63'd0, cout_m}, {63'd0, ec});
        @(posedge clk); #1;
        chk({name, "_idle"}, {63'd0, in_ready_m}, 64'd1);
    endtask

    // Result checker: compares against the model on every valid cycle.
    initial begin
        logic prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                chk("ready_vs_busy", {63'd0, in_ready_m}, {63'd0, !busy_m});
                if (out_valid_m) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'(exp_q.size()), 64'd1);
                    end else begin
                        chk("model_sum", sum_m, exp_q[0].sum);
                        chk("model_cout", {63'd0, cout_m}, {63'd0, exp_q[0].cout});
                        if (!prev_ov)
                            chk("latency", 64'(cyc - exp_q[0].acc), 64'(1 << sel));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                prev_ov = out_valid_m;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        e = golden(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 32);
        chk("model_wrap", {e.cout, e.sum[62:0]}, {1'b1, 63'd0});
        e = golden(64'd5, 64'd7, 1'b1, 1'b1, 32);
        chk("model_sub", {e.cout, e.sum[62:0]}, {1'b0, 63'hFFFF_FFFE});

        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_in_ready", {63'd0, in_ready_m}, 64'd1);
            chk("rst_out_valid", {63'd0, out_valid_m}, 64'd0);
            chk("rst_busy", {63'd0, busy_m}, 64'd0);
            chk("rst_sum", sum_m, 64'd0);
            chk("rst_cout", {63'd0, cout_m}, 64'd0);
        end
        sel = 1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        op_lit("carry_seg", 64'h0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000, 1'b0);
        op_lit("wrap_add", 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1);
        op_lit("wrap_cin", 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
        op_lit("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFE, 1'b0);
        op_lit("sub_ok", 64'd7, 64'd5, 1'b0, 1'b1, 64'h2, 1'b1);

        // Backpressure with scrambled inputs and ignored in_valid pulses.
        out_ready = 1'b0;
        send(64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0);
        wait_result();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", sum_m, 64'h2345_6789);
            chk("bp_in_ready", {63'd0, in_ready_m}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid_m}, 64'd1);
            in_valid = (i == 1 || i == 2);
            a_in = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {63'd0, in_ready_m}, 64'd1);
        chk("bp_release_valid", {63'd0, out_valid_m}, 64'd0);

        // Reset after the first segment edge of a 4-segment operation.
        sel = 2;
        @(posedge clk); #1;
        send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("partial_seg0", sum_m, 64'h0000_0000_0000_3333);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid_m}, 64'd0);
        chk("midrst_busy", {63'd0, busy_m}, 64'd0);
        chk("midrst_sum", sum_m, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready_m}, 64'd1);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", {63'd0, in_ready_m}, 64'd1);
        op_lit("postrst_add", 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0);

        // Random regression with random output stalls.
        rand_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(posedge clk); #1;
            for (int i = 0; i < 1000; i++)
                send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            chk("drain", 64'(exp_q.size()), 64'd0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
